// File: rtl/acondicionamiento_entradas_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | acondicionamiento_entradas_if: raw switch/button inputs, conditioned outs |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface acondicionamiento_entradas_if;
   logic [3:0] operandoCrudoA;
   logic [3:0] operandoCrudoB;
   logic       botonCrudo;
   logic [3:0] operandoEstableA;
   logic [3:0] operandoEstableB;
   logic       botonEstable;
   logic       pulsoIniciar;
   logic       pulsoCambio;

   // Board / consumer side: drives the raw inputs, receives the conditioned values.
   modport master (
      output operandoCrudoA,
      output operandoCrudoB,
      output botonCrudo,
      input  operandoEstableA,
      input  operandoEstableB,
      input  botonEstable,
      input  pulsoIniciar,
      input  pulsoCambio
   );

   modport slave (
      input  operandoCrudoA,
      input  operandoCrudoB,
      input  botonCrudo,
      output operandoEstableA,
      output operandoEstableB,
      output botonEstable,
      output pulsoIniciar,
      output pulsoCambio
   );
endinterface
`default_nettype wire

// File: rtl/acondicionamiento_entradas.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | acondicionamiento_entradas: sync + debounce of operand switches & button |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module acondicionamiento_entradas #(
   parameter int CICLOS_ESTABLE = 50000,
   parameter int ANCHO_CONTADOR = 16
) (
   input  logic                          reloj,
   input  logic                          reinicio,
   acondicionamiento_entradas_if.slave   bus
);

   // The increment that would make the count reach CICLOS_ESTABLE-1 is the
   // accepting edge, so the stored count never exceeds CICLOS_ESTABLE-2.
   localparam logic [ANCHO_CONTADOR-1:0] CUENTA_FINAL = ANCHO_CONTADOR'(CICLOS_ESTABLE - 2);
   localparam logic [ANCHO_CONTADOR-1:0] UNO          = ANCHO_CONTADOR'(1);

   typedef enum logic [1:0] {
      REPOSO              = 2'd0,
      CONFIRMA_PRESION    = 2'd1,
      PRESIONADO          = 2'd2,
      CONFIRMA_LIBERACION = 2'd3
   } estado_t;

   logic [8:0] sync_meta;
   logic [8:0] sync_final;
   logic [8:0] crudo;

   logic [3:0] sync_a;
   logic [3:0] sync_b;
   logic       sync_boton;

   assign crudo = {bus.botonCrudo, bus.operandoCrudoB, bus.operandoCrudoA};

   always_ff @(posedge reloj) begin
      if (reinicio) begin
         sync_meta  <= '0;
         sync_final <= '0;
      end else begin
         sync_meta  <= crudo;
         sync_final <= sync_meta;
      end
   end

   assign sync_a     = sync_final[3:0];
   assign sync_b     = sync_final[7:4];
   assign sync_boton = sync_final[8];

   // ---------------- operand A debounce ----------------
   logic [3:0]                cand_a;
   logic [3:0]                cand_a_sig;
   logic [3:0]                estable_a;
   logic [3:0]                estable_a_sig;
   logic [ANCHO_CONTADOR-1:0] cnt_a;
   logic [ANCHO_CONTADOR-1:0] cnt_a_sig;
   logic                      act_a;

   always_comb begin
      cand_a_sig    = cand_a;
      estable_a_sig = estable_a;
      cnt_a_sig     = cnt_a;
      act_a         = 1'b0;
      if (sync_a != cand_a) begin
         cand_a_sig = sync_a;
         cnt_a_sig  = '0;
      end else if (cand_a != estable_a) begin
         if (cnt_a == CUENTA_FINAL) begin
            estable_a_sig = cand_a;
            cnt_a_sig     = '0;
            act_a         = 1'b1;
         end else begin
            cnt_a_sig = cnt_a + UNO;
         end
      end else begin
         cnt_a_sig = '0;
      end
   end

   always_ff @(posedge reloj) begin
      if (reinicio) begin
         cand_a    <= '0;
         estable_a <= '0;
         cnt_a     <= '0;
      end else begin
         cand_a    <= cand_a_sig;
         estable_a <= estable_a_sig;
         cnt_a     <= cnt_a_sig;
      end
   end

   // ---------------- operand B debounce ----------------
   logic [3:0]                cand_b;
   logic [3:0]                cand_b_sig;
   logic [3:0]                estable_b;
   logic [3:0]                estable_b_sig;
   logic [ANCHO_CONTADOR-1:0] cnt_b;
   logic [ANCHO_CONTADOR-1:0] cnt_b_sig;
   logic                      act_b;

   always_comb begin
      cand_b_sig    = cand_b;
      estable_b_sig = estable_b;
      cnt_b_sig     = cnt_b;
      act_b         = 1'b0;
      if (sync_b != cand_b) begin
         cand_b_sig = sync_b;
         cnt_b_sig  = '0;
      end else if (cand_b != estable_b) begin
         if (cnt_b == CUENTA_FINAL) begin
            estable_b_sig = cand_b;
            cnt_b_sig     = '0;
            act_b         = 1'b1;
         end else begin
            cnt_b_sig = cnt_b + UNO;
         end
      end else begin
         cnt_b_sig = '0;
      end
   end

   always_ff @(posedge reloj) begin
      if (reinicio) begin
         cand_b    <= '0;
         estable_b <= '0;
         cnt_b     <= '0;
      end else begin
         cand_b    <= cand_b_sig;
         estable_b <= estable_b_sig;
         cnt_b     <= cnt_b_sig;
      end
   end

   // Simultaneous A/B updates collapse into a single change pulse.
   logic pulso_cambio;

   always_ff @(posedge reloj) begin
      if (reinicio) begin
         pulso_cambio <= 1'b0;
      end else begin
         pulso_cambio <= act_a | act_b;
      end
   end

   // ---------------- button FSM ----------------
   estado_t                   estado;
   estado_t                   estado_sig;
   logic [ANCHO_CONTADOR-1:0] cnt_boton;
   logic [ANCHO_CONTADOR-1:0] cnt_boton_sig;
   logic                      pulso_iniciar;
   logic                      pulso_iniciar_sig;
   logic                      boton_estable;
   logic                      boton_estable_sig;

   always_ff @(posedge reloj) begin
      if (reinicio) begin
         estado        <= REPOSO;
         cnt_boton     <= '0;
         pulso_iniciar <= 1'b0;
         boton_estable <= 1'b0;
      end else begin
         estado        <= estado_sig;
         cnt_boton     <= cnt_boton_sig;
         pulso_iniciar <= pulso_iniciar_sig;
         boton_estable <= boton_estable_sig;
      end
   end

   always_comb begin
      estado_sig        = estado;
      cnt_boton_sig     = cnt_boton;
      pulso_iniciar_sig = 1'b0;
      case (estado)
         REPOSO: begin
            cnt_boton_sig = '0;
            if (sync_boton) begin
               estado_sig = CONFIRMA_PRESION;
            end
         end
         CONFIRMA_PRESION: begin
            if (!sync_boton) begin
               estado_sig    = REPOSO;
               cnt_boton_sig = '0;
            end else if (cnt_boton == CUENTA_FINAL) begin
               estado_sig        = PRESIONADO;
               cnt_boton_sig     = '0;
               pulso_iniciar_sig = 1'b1;
            end else begin
               cnt_boton_sig = cnt_boton + UNO;
            end
         end
         PRESIONADO: begin
            cnt_boton_sig = '0;
            if (!sync_boton) begin
               estado_sig = CONFIRMA_LIBERACION;
            end
         end
         CONFIRMA_LIBERACION: begin
            if (sync_boton) begin
               estado_sig    = PRESIONADO;
               cnt_boton_sig = '0;
            end else if (cnt_boton == CUENTA_FINAL) begin
               estado_sig    = REPOSO;
               cnt_boton_sig = '0;
            end else begin
               cnt_boton_sig = cnt_boton + UNO;
            end
         end
         default: begin
            estado_sig    = REPOSO;
            cnt_boton_sig = '0;
         end
      endcase
      // The stable level holds through the release confirmation window.
      boton_estable_sig = (estado_sig == PRESIONADO) || (estado_sig == CONFIRMA_LIBERACION);
   end

   assign bus.operandoEstableA = estable_a;
   assign bus.operandoEstableB = estable_b;
   assign bus.botonEstable     = boton_estable;
   assign bus.pulsoIniciar     = pulso_iniciar;
   assign bus.pulsoCambio      = pulso_cambio;

endmodule
`default_nettype wire

// File: tb/tb_acondicionamiento_entradas.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_acondicionamiento_entradas: directed bench, CICLOS_ESTABLE = 4         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_acondicionamiento_entradas;

   logic reloj = 1'b0;
   logic reinicio;
   int   total = 0;
   int   bad   = 0;

   always #5 reloj = ~reloj;

   acondicionamiento_entradas_if bus ();

   acondicionamiento_entradas #(
      .CICLOS_ESTABLE (4),
      .ANCHO_CONTADOR (16)
   ) dut (
      .reloj    (reloj),
      .reinicio (reinicio),
      .bus      (bus.slave)
   );

   task automatic tick;
      @(posedge reloj);
      #1;
   endtask

   task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      total++;
      if (obs !== esp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
      end
   endtask

   task automatic crudo(input logic [3:0] a, input logic [3:0] b, input logic boton);
      bus.operandoCrudoA = a;
      bus.operandoCrudoB = b;
      bus.botonCrudo     = boton;
   endtask

   function automatic logic [31:0] salidas();
      return {21'd0, bus.operandoEstableA, bus.operandoEstableB,
              bus.botonEstable, bus.pulsoIniciar, bus.pulsoCambio};
   endfunction

   task automatic reiniciar;
      crudo(4'h0, 4'h0, 1'b0);
      reinicio = 1'b1;
      tick();
      tick();
      verificar("reiniciar_salidas", salidas(), 32'h0);
      reinicio = 1'b0;
      tick();
   endtask

   initial begin
      // Reset with every raw input high, then let them propagate.
      reinicio = 1'b1;
      crudo(4'hF, 4'hF, 1'b1);
      for (int n = 1; n <= 3; n++) begin
         tick();
         verificar($sformatf("reset_unos_%0d", n), salidas(), 32'h0);
      end
      reinicio = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         tick();
         verificar($sformatf("arranque_boton_%0d", n), bus.botonEstable, (n >= 6));
         verificar($sformatf("arranque_pulso_%0d", n), bus.pulsoIniciar, (n == 6));
         verificar($sformatf("arranque_cambio_%0d", n), bus.pulsoCambio, (n == 6));
         verificar($sformatf("arranque_a_%0d", n), bus.operandoEstableA, (n >= 6) ? 32'hF : 32'h0);
         verificar($sformatf("arranque_b_%0d", n), bus.operandoEstableB, (n >= 6) ? 32'hF : 32'h0);
      end

      // Clean press held 20 cycles, then released.
      reiniciar();
      crudo(4'h0, 4'h0, 1'b1);
      for (int n = 1; n <= 20; n++) begin
         tick();
         verificar($sformatf("pulsar_pulso_%0d", n), bus.pulsoIniciar, (n == 6));
         verificar($sformatf("pulsar_boton_%0d", n), bus.botonEstable, (n >= 6));
      end
      crudo(4'h0, 4'h0, 1'b0);
      for (int n = 1; n <= 10; n++) begin
         tick();
         verificar($sformatf("soltar_boton_%0d", n), bus.botonEstable, (n < 6));
         verificar($sformatf("soltar_pulso_%0d", n), bus.pulsoIniciar, 32'h0);
      end

      // Bounce 1,0,1,0 then steady high.
      reiniciar();
      for (int n = 0; n < 4; n++) begin
         crudo(4'h0, 4'h0, (n % 2 == 0));
         tick();
         verificar($sformatf("rebote_pulso_%0d", n), bus.pulsoIniciar, 32'h0);
      end
      crudo(4'h0, 4'h0, 1'b1);
      for (int n = 1; n <= 10; n++) begin
         tick();
         verificar($sformatf("rebote_final_pulso_%0d", n), bus.pulsoIniciar, (n == 6));
         verificar($sformatf("rebote_final_boton_%0d", n), bus.botonEstable, (n >= 6));
      end

      // Operand A: 5, glitch to 7 for two cycles, back to 5.
      reiniciar();
      crudo(4'h5, 4'h0, 1'b0);
      for (int n = 1; n <= 2; n++) begin
         tick();
         verificar($sformatf("glitch_pre_a_%0d", n), bus.operandoEstableA, 32'h0);
      end
      crudo(4'h7, 4'h0, 1'b0);
      for (int n = 1; n <= 2; n++) begin
         tick();
         verificar($sformatf("glitch_a_%0d", n), bus.operandoEstableA, 32'h0);
         verificar($sformatf("glitch_cambio_%0d", n), bus.pulsoCambio, 32'h0);
      end
      crudo(4'h5, 4'h0, 1'b0);
      for (int n = 1; n <= 10; n++) begin
         tick();
         verificar($sformatf("glitch_post_a_%0d", n), bus.operandoEstableA, (n >= 6) ? 32'h5 : 32'h0);
         verificar($sformatf("glitch_post_cambio_%0d", n), bus.pulsoCambio, (n == 6));
      end

      // A and B change together: one shared pulse.
      reiniciar();
      crudo(4'h3, 4'hA, 1'b0);
      for (int n = 1; n <= 8; n++) begin
         tick();
         verificar($sformatf("ab_valores_%0d", n),
                   {24'd0, bus.operandoEstableA, bus.operandoEstableB},
                   (n >= 6) ? 32'h3A : 32'h0);
         verificar($sformatf("ab_cambio_%0d", n), bus.pulsoCambio, (n == 6));
      end

      // Reset in the middle of a press confirmation, button kept held.
      reiniciar();
      crudo(4'h0, 4'h0, 1'b1);
      for (int n = 1; n <= 4; n++) begin
         tick();
         verificar($sformatf("mid_pre_pulso_%0d", n), bus.pulsoIniciar, 32'h0);
      end
      reinicio = 1'b1;
      for (int n = 1; n <= 3; n++) begin
         tick();
         verificar($sformatf("mid_reset_pulso_%0d", n), bus.pulsoIniciar, 32'h0);
         verificar($sformatf("mid_reset_boton_%0d", n), bus.botonEstable, 32'h0);
      end
      reinicio = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         tick();
         verificar($sformatf("mid_post_pulso_%0d", n), bus.pulsoIniciar, (n == 6));
         verificar($sformatf("mid_post_boton_%0d", n), bus.botonEstable, (n >= 6));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
